// File: rtl/sa_ram_pkg.sv
// Shared geometry for the 64x14 read-with-staged-pipeline RAM and its FIFO controller.
package sa_ram_pkg;
  localparam int unsigned Depth = 64;
  localparam int unsigned Width = 14;
  localparam int unsigned AddrW = 6;
  localparam int unsigned OccW  = 7;
endpackage

// File: rtl/sa_ram_rwsp_64x14.sv
// Behavioural 64x14 RAM with a registered read address and a registered output stage.
module sa_ram_rwsp_64x14
  import sa_ram_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] wa,
  input  logic [Width-1:0] di,
  input  logic             re,
  input  logic [AddrW-1:0] ra,
  input  logic             ore,
  output logic [Width-1:0] dout,
  input  logic             pwrbus_ram_pd
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] ra_q;
  logic [Width-1:0] dout_q;

  // Contents are deliberately left unreset; writes are blocked while powered down.
  always_ff @(posedge clk) begin
    if (we && !pwrbus_ram_pd) mem_q[wa] <= di;
    if (re)                   ra_q      <= ra;
    if (ore)                  dout_q    <= mem_q[ra_q];
  end

  assign dout = dout_q;

endmodule

// File: rtl/sa_fifo_ctl_rwsp_64x14.sv
// FIFO controller driving a RAM with a registered address stage (S1) and output stage (S2).
module sa_fifo_ctl_rwsp_64x14
  import sa_ram_pkg::*;
#(
  parameter int unsigned DEPTH = Depth,
  parameter int unsigned WIDTH = Width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AddrW-1:0] ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AddrW-1:0] ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [OccW-1:0]  occupancy
);

  localparam logic [OccW-1:0]  FullCount = OccW'(DEPTH);
  localparam logic [AddrW-1:0] LastAddr  = AddrW'(DEPTH - 1);

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  pending_q, pending_d;
  logic [OccW-1:0]  ram_count_q, ram_count_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             wr_fire;

  always_comb begin
    wr_ready = (ram_count_q < FullCount);
    wr_fire  = wr_valid && wr_ready;
    ram_ore  = s1_q && (!s2_q || rd_ready);
    ram_re   = (pending_q != '0) && (!s1_q || ram_ore);

    ram_we = wr_fire;
    ram_wa = wr_ptr_q;
    ram_di = wr_data;
    ram_ra = rd_ptr_q;

    rd_valid  = s2_q;
    rd_data   = ram_dout;
    occupancy = ram_count_q + OccW'(s2_q);

    wr_ptr_d = wr_ptr_q;
    if (wr_fire) wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (ram_re) rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;

    pending_d   = pending_q + OccW'(wr_fire) - OccW'(ram_re);
    // A slot stays allocated until its word is captured by the output register.
    ram_count_d = ram_count_q + OccW'(wr_fire) - OccW'(ram_ore);

    s1_d = s1_q;
    if (ram_re)       s1_d = 1'b1;
    else if (ram_ore) s1_d = 1'b0;

    s2_d = s2_q;
    if (ram_ore)       s2_d = 1'b1;
    else if (rd_ready) s2_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pending_q   <= '0;
      ram_count_q <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_q   <= pending_d;
      ram_count_q <= ram_count_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end

endmodule

// File: tb/tb_sa_fifo_ctl_rwsp_64x14.sv
// Scoreboard bench: controller paired with the RAM model, directed and stall-pattern traffic.
module tb_sa_fifo_ctl_rwsp_64x14;
  import sa_ram_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_valid, wr_ready, rd_valid, rd_ready;
  logic [Width-1:0] wr_data, rd_data, ram_di, ram_dout;
  logic [AddrW-1:0] ram_wa, ram_ra;
  logic             ram_we, ram_re, ram_ore;
  logic [OccW-1:0]  occupancy;

  always #5 clk = ~clk;

  sa_fifo_ctl_rwsp_64x14 dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .ram_wa(ram_wa),
    .ram_we(ram_we), .ram_di(ram_di), .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
    .ram_dout(ram_dout), .occupancy(occupancy)
  );

  sa_ram_rwsp_64x14 u_ram (
    .clk(clk), .we(ram_we), .wa(ram_wa), .di(ram_di), .re(ram_re), .ra(ram_ra),
    .ore(ram_ore), .dout(ram_dout), .pwrbus_ram_pd(1'b0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_push   = 0;
  logic [Width-1:0] sb [$];
  logic [Width-1:0] exp_word, last_pop, stall_data;
  logic             stall_q = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: push accepted writes, pop and compare every consumed word, check hold under stall.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall_q = 1'b0;
      n_push  = 0;
    end else begin
      if (wr_valid && wr_ready) begin
        sb.push_back(wr_data);
        n_push++;
      end
      if (rd_valid && stall_q) chk("rd_hold", int'(rd_data), int'(stall_data));
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_empty: got 0x%0h expected no word", rd_data);
        end else begin
          exp_word = sb.pop_front();
          chk("rd_data", int'(rd_data), int'(exp_word));
        end
        last_pop = rd_data;
        n_pop++;
      end
      stall_q    = rd_valid && !rd_ready;
      stall_data = rd_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    while ((sb.size() != 0 || rd_valid) && t < 300) begin
      cyc();
      t++;
    end
    chk("drain_done", int'(t < 300), 1);
  endtask

  task automatic stream(input int n, input int mode, input int seed);
    int acc = 0;
    int t   = 0;
    int base = n_pop;
    while (acc < n && t < 8000) begin
      if (mode == 0) begin
        rd_ready = 1'($urandom_range(0, 1));
        wr_valid = 1'b1;
      end else begin
        rd_ready = ((t % 7) != 3);
        wr_valid = ((t % 11) != 5);
      end
      wr_data = Width'(acc * 37 + seed);
      @(negedge clk);
      if (wr_valid && wr_ready) acc++;
      cyc();
      t++;
    end
    chk("stream_accepted", acc, n);
    drain();
    chk("stream_popped", n_pop - base, n);
    chk("wrap_wa", int'(ram_wa), n_push % 64);
    chk("wrap_ra", int'(ram_ra), n_push % 64);
  endtask

  initial begin
    int base;
    int acc;
    int t;
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_re", int'(ram_re), 0);
    chk("rst_ram_ore", int'(ram_ore), 0);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_wa", int'(ram_wa), 0);
    chk("rst_ra", int'(ram_ra), 0);

    // Single word: 3-cycle latency, occupancy 1,1,1,0.
    cyc();
    wr_valid = 1'b1; wr_data = 14'h1A5; rd_ready = 1'b1;
    @(negedge clk);
    chk("sw_we", int'(ram_we), 1);
    chk("sw_di", int'(ram_di), 'h1A5);
    chk("sw_occ0", int'(occupancy), 0);
    cyc(); wr_valid = 1'b0;
    @(negedge clk);
    chk("sw_occ1", int'(occupancy), 1);
    chk("sw_re1", int'(ram_re), 1);
    chk("sw_valid1", int'(rd_valid), 0);
    cyc();
    @(negedge clk);
    chk("sw_occ2", int'(occupancy), 1);
    chk("sw_ore2", int'(ram_ore), 1);
    chk("sw_valid2", int'(rd_valid), 0);
    cyc();
    @(negedge clk);
    chk("sw_valid3", int'(rd_valid), 1);
    chk("sw_data3", int'(rd_data), 'h1A5);
    chk("sw_occ3", int'(occupancy), 1);
    cyc();
    @(negedge clk);
    chk("sw_occ4", int'(occupancy), 0);
    chk("sw_valid4", int'(rd_valid), 0);

    // Streaming: 200 back-to-back words, no bubbles after priming.
    cyc();
    base = n_pop;
    for (int i = 0; i < 200; i++) begin
      wr_valid = 1'b1; wr_data = Width'(i);
      @(negedge clk);
      if (!wr_ready) chk("stream_wr_ready", int'(wr_ready), 1);
      cyc();
    end
    wr_valid = 1'b0;
    chk("stream_pops_c200", n_pop - base, 197);
    repeat (3) cyc();
    chk("stream_pops_c203", n_pop - base, 200);

    // Fill with the consumer stalled: 65 words held, then same-cycle write+pop at full.
    drain();
    rd_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 70; c++) begin
      wr_valid = 1'b1; wr_data = Width'(14'h100 + acc);
      @(negedge clk);
      if (wr_ready) acc++;
      cyc();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", acc, 65);
    chk("fill_wr_ready", int'(wr_ready), 0);
    chk("fill_occ", int'(occupancy), 65);
    chk("fill_valid", int'(rd_valid), 1);
    chk("fill_re_idle", int'(ram_re), 0);
    chk("fill_ore_idle", int'(ram_ore), 0);
    chk("fill_head", int'(rd_data), 'h100);
    cyc();
    wr_valid = 1'b1; wr_data = 14'h141; rd_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_wr_ready", int'(wr_ready), 0);
    cyc(); wr_valid = 1'b0;
    @(negedge clk);
    chk("after_pop_wr_ready", int'(wr_ready), 1);
    drain();

    stream(1000, 0, 5);
    stream(130, 1, 9);

    // Reset mid-stream at occupancy 10.
    rd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_data = Width'(14'h200 + i);
      cyc();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("mid_occ", int'(occupancy), 10);
    cyc();
    rst = 1'b1; wr_valid = 1'b1; wr_data = 14'h155; rd_ready = 1'b1;
    cyc();
    rst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(rd_valid), 0);
    chk("mid_rst_occ", int'(occupancy), 0);
    chk("mid_rst_wr_ready", int'(wr_ready), 1);
    cyc();
    base = n_pop;
    wr_valid = 1'b1; wr_data = 14'h3FF;
    cyc();
    wr_valid = 1'b0;
    t = 0;
    while (n_pop == base && t < 20) begin
      cyc();
      t++;
    end
    chk("mid_first_popped", int'(n_pop > base), 1);
    chk("mid_first_word", int'(last_pop), 'h3FF);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_fifo_ctl_rwsp_64x14.md
SA_FIFO_CTL_RWSP_64X14 -- requirements
Module: sa_fifo_ctl_rwsp_64x14

Interface
REQ-001 Parameter DEPTH, default 64, SHALL be the number of RAM words; parameter WIDTH, default 14, SHALL be the data width.
REQ-002 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 wr_valid  input  1  producer has a word.
REQ-005 wr_ready  output  1  controller can accept a word.
REQ-006 wr_data  input  14  producer word.
REQ-007 rd_valid  output  1  rd_data holds a word.
REQ-008 rd_ready  input  1  consumer takes the word.
REQ-009 rd_data  output  14  consumer word.
REQ-010 ram_wa  output  6  RAM write address.
REQ-011 ram_we  output  1  RAM write enable.
REQ-012 ram_di  output  14  RAM write data.
REQ-013 ram_ra  output  6  RAM read address.
REQ-014 ram_re  output  1  RAM read-address register enable.
REQ-015 ram_ore  output  1  RAM output-register enable.
REQ-016 ram_dout  input  14  RAM output-register contents.
REQ-017 occupancy  output  7  words held (RAM plus RAM output register), range 0..65.

Function
REQ-018 The RAM model SHALL be taken as: the write lands at the edge where we=1; ra is captured at the edge where re=1; M[captured ra] is captured into dout at the edge where ore=1.
REQ-019 A write SHALL occur in any cycle with wr_valid && wr_ready: ram_we=1, ram_wa=wr_ptr, ram_di=wr_data, and wr_ptr increments modulo 64.
REQ-020 Stage S1 valid SHALL mean the RAM address register holds an unconsumed slot address; S2 valid SHALL mean the RAM output register holds an unconsumed word.
REQ-021 ram_ore SHALL equal S1 && (!S2 || rd_ready).
REQ-022 ram_re SHALL equal (pending>0) && (!S1 || ram_ore), where pending is the count of written, unissued words; ram_ra=rd_ptr, and rd_ptr increments modulo 64 on ram_re.
REQ-023 rd_valid SHALL equal S2; rd_data SHALL equal ram_dout combinationally.
REQ-024 A RAM slot SHALL be freed only on ram_ore, because the slot is read combinationally until capture.
REQ-025 ram_count (slots not yet freed) SHALL increment on a write, decrement on ram_ore, and be unchanged when both occur; wr_ready SHALL equal ram_count<64.
REQ-026 pending SHALL be a registered count, so a word written at edge t issues no earlier than cycle t+1 and rd_valid asserts at t+3.
REQ-027 occupancy SHALL equal ram_count + S2.
REQ-028 Sustained throughput SHALL be one word per cycle in both directions with no bubbles once primed.
REQ-029 When full (ram_count=64), a write and a pop in the same cycle SHALL leave the write not accepted, since wr_ready is registered-state based.
REQ-030 Word order SHALL be strict FIFO, including across pointer wrap 63->0.
REQ-031 With rd_ready=0, S1, S2, ram_ra captured value, and ram_dout SHALL hold; ram_re and ram_ore SHALL be 0 while both stages are full.

Reset
REQ-032 While rst=1, wr_ptr, rd_ptr, pending, ram_count, S1, and S2 SHALL clear at the next edge, discarding in-flight words.
REQ-033 Reset outputs SHALL be: wr_ready=1, rd_valid=0, ram_we=0, ram_re=0, ram_ore=0, occupancy=0, and ram_wa=ram_ra=0.
REQ-034 RAM contents SHALL not be cleared; stale ram_dout is masked by S2=0.
REQ-035 Reset asserted mid-transfer SHALL override every same-cycle handshake.

Structure
REQ-036 DEPTH, WIDTH, the derived address width 6, and the occupancy width 7 SHALL live in a shared package, sa_ram_pkg.
REQ-037 The block SHALL be flat with no sub-module; a top-level test wrapper SHALL pair it with sa_ram_rwsp_64x14 (pwrbus_ram_pd tied 0).

Verification
REQ-038 Single word: write 0x1A5 at cycle 0 with rd_ready=1 -> rd_valid at cycle 3 with rd_data=0x1A5, and occupancy 1,1,1,0.
REQ-039 Streaming: write 200 words 0..199 back-to-back with rd_ready=1 -> identical order out, one per cycle after 3-cycle latency, wr_ready never drops.
REQ-040 Fill: rd_ready=0, write 70 words -> 65 accepted, wr_ready=0 at occupancy 65, ram_count=64; then rd_ready=1 -> words 0..64 in order.
REQ-041 Backpressure: random rd_ready toggling (50%) over 1000 words -> no loss or duplication, and rd_data stable while rd_valid && !rd_ready.
REQ-042 Wrap: 130 words with occasional stalls -> pointers wrap twice with correct order.
REQ-043 Reset mid-stream: rst for 1 cycle at occupancy 10 -> next cycle rd_valid=0, occupancy=0, wr_ready=1, and a subsequent write 0x3FF emerges first.
